// File: rtl/de2i_150_qsys_memory_stream_reader.sv
// Avalon-MM read master that streams a contiguous block of on-chip memory words
// out of a ready/valid Avalon-ST source, one packet per start command.
module de2i_150_qsys_memory_stream_reader #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_address,
  input  logic [ADDR_WIDTH:0]     word_count,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   m_address,
  output logic                    m_chipselect,
  output logic                    m_write,
  output logic [DATA_WIDTH/8-1:0] m_byteenable,
  output logic [DATA_WIDTH-1:0]   m_writedata,
  output logic                    m_clken,
  input  logic [DATA_WIDTH-1:0]   m_readdata,
  output logic [DATA_WIDTH-1:0]   st_data,
  output logic                    st_valid,
  input  logic                    st_ready,
  output logic                    st_startofpacket,
  output logic                    st_endofpacket
);

  localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
  localparam int CRED_WIDTH = PTR_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_WIDTH-1:0]  count_q, issued_q, delivered_q, last_index;
  logic                  inflight_q, done_q;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0]    fifo_count;
  logic [CRED_WIDTH-1:0] credit_used;

  logic accept, issue, fifo_empty, pop, push, fifo_pop, last_pop;

  assign m_write      = 1'b0;
  assign m_byteenable = '1;
  assign m_writedata  = '0;
  assign m_clken      = 1'b1;

  assign busy         = (state != IDLE);
  assign done         = done_q;
  assign m_chipselect = issue;
  assign m_address    = base_q + issued_q[ADDR_WIDTH-1:0];

  assign accept      = (state == IDLE) && start;
  assign last_index  = count_q - CNT_WIDTH'(1);
  assign credit_used = CRED_WIDTH'(fifo_count) + CRED_WIDTH'(inflight_q);

  // With the buffer empty, the word returning from memory is presented directly
  // so that an unstalled stream keeps one word per cycle with a 2-cycle latency.
  assign fifo_empty = (fifo_count == '0);
  assign st_valid   = !fifo_empty || inflight_q;
  assign st_data    = !fifo_empty ? fifo_mem[rd_ptr] : (inflight_q ? m_readdata : '0);
  assign pop        = st_valid && st_ready;
  assign fifo_pop   = pop && !fifo_empty;
  assign push       = inflight_q && !(fifo_empty && pop);

  assign st_startofpacket = st_valid && (delivered_q == '0);
  assign st_endofpacket   = st_valid && (delivered_q == last_index);
  assign last_pop         = pop && st_endofpacket;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves a latch.
    state_next = state;
    issue      = 1'b0;
    unique case (state)
      IDLE: if (start && word_count != '0) state_next = RUN;
      RUN: begin
        issue = (issued_q < count_q) && (credit_used < CRED_WIDTH'(FIFO_DEPTH));
        if (issue && issued_q == last_index) state_next = DRAIN;
      end
      DRAIN: if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
    end else begin
      state      <= state_next;
      inflight_q <= issue;
      done_q     <= (accept && word_count == '0) || (state == DRAIN && last_pop);

      if (accept) begin
        base_q      <= base_address;
        count_q     <= word_count;
        issued_q    <= '0;
        delivered_q <= '0;
      end else begin
        if (issue) issued_q <= issued_q + CNT_WIDTH'(1);
        if (pop)   delivered_q <= delivered_q + CNT_WIDTH'(1);
      end

      if (push)     wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      if (push && !fifo_pop)      fifo_count <= fifo_count + (PTR_WIDTH+1)'(1);
      else if (!push && fifo_pop) fifo_count <= fifo_count - (PTR_WIDTH+1)'(1);
    end
  end

  // NOTE: the buffer storage has no reset; occupancy is tracked by the reset
  // pointers and count, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= m_readdata;
  end

endmodule

// File: tb/tb_de2i_150_qsys_memory_stream_reader.sv
// Self-checking bench: a queue-based packet model checked every cycle, plus
// directed cycle-exact expectations for the main scenarios.
module tb_de2i_150_qsys_memory_stream_reader;

  localparam int AW    = 14;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_address = '0;
  logic [AW:0]   word_count = '0;
  logic          busy, done;
  logic [AW-1:0] m_address;
  logic          m_chipselect, m_write, m_clken;
  logic [DW/8-1:0] m_byteenable;
  logic [DW-1:0] m_writedata;
  logic [DW-1:0] m_readdata = '0;
  logic [DW-1:0] st_data;
  logic          st_valid;
  logic          st_ready = 1'b0;
  logic          st_startofpacket, st_endofpacket;

  de2i_150_qsys_memory_stream_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_address(base_address),
    .word_count(word_count), .busy(busy), .done(done),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata), .m_clken(m_clken),
    .m_readdata(m_readdata), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_startofpacket(st_startofpacket),
    .st_endofpacket(st_endofpacket)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [WORDS];
  initial for (int k = 0; k < WORDS; k++) mem[k] = DW'(k);

  // Registered memory port: data one cycle after an issue, junk otherwise.
  always @(posedge clk)
    m_readdata <= m_chipselect ? mem[m_address] : 64'hBAD0_BAD0_BAD0_BAD0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } word_t;

  word_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  bit            m_busy = 0;
  bit            exp_done = 0;
  bit            prev_reset = 1;
  int            outstanding = 0;
  int            done_pulses = 0;
  int            eop_hs = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      addr_q.delete();
      m_busy      = 0;
      exp_done    = 0;
      outstanding = 0;
      prev_reset  = 1;
    end else begin
      bit next_done;
      bit hs;
      if (prev_reset) begin
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", st_valid, 0);
        check("rst_cs", m_chipselect, 0);
        check("rst_addr", m_address, 0);
        check("rst_data", st_data, 0);
        check("rst_sop", st_startofpacket, 0);
        check("rst_eop", st_endofpacket, 0);
      end else begin
        check("done", done, exp_done);
        check("busy", busy, m_busy);
      end
      if (done) done_pulses++;

      if (m_chipselect) begin
        if (addr_q.size() == 0) check("extra_issue", m_chipselect, 0);
        else check("issue_addr", m_address, addr_q.pop_front());
        outstanding++;
      end
      if (outstanding > DEPTH) check("occupancy", outstanding, DEPTH);

      hs = st_valid && st_ready;
      next_done = 0;
      if (st_valid) begin
        if (exp_q.size() == 0) check("spurious_valid", st_valid, 0);
        else begin
          check("st_data", st_data, exp_q[0].d);
          check("st_sop", st_startofpacket, exp_q[0].sop);
          check("st_eop", st_endofpacket, exp_q[0].eop);
        end
      end
      if (hs) begin
        if (st_endofpacket) eop_hs++;
        if (exp_q.size() > 0) begin
          if (exp_q[0].eop) begin
            next_done = 1;
            m_busy    = 0;
          end
          void'(exp_q.pop_front());
        end
        outstanding--;
      end

      if (start && !m_busy) begin
        if (word_count == 0) next_done = 1;
        else begin
          m_busy = 1;
          for (int i = 0; i < int'(word_count); i++) begin
            logic [AW-1:0] a;
            a = AW'(int'(base_address) + i);
            addr_q.push_back(a);
            exp_q.push_back('{d: mem[a], sop: (i == 0), eop: (i == int'(word_count) - 1)});
          end
        end
      end
      exp_done   = next_done;
      prev_reset = 0;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
    start        = 1'b1;
    base_address = b;
    word_count   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    bit got = 0;
    for (int c = 0; c < budget && !got; c++) begin
      st_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (done) got = 1;
      tick();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL wait_done timeout: no done within %0d cycles", budget);
    end
  endtask

  initial begin
    logic [AW-1:0] wrap_addr [4];
    int cs;
    int d0, e0;
    wrap_addr = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};

    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Basic packet, then a back-to-back start accepted in the done cycle.
    st_ready = 1'b1;
    do_start(14'h10, 15'd8);
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) begin
        start = 1'b1; base_address = 14'h40; word_count = 15'd2;
      end
      @(negedge clk);
      check("t1_valid", st_valid, (c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) check("t1_data", st_data, 64'h10 + 64'(c - 2));
      check("t1_sop", st_startofpacket, (c == 2));
      check("t1_eop", st_endofpacket, (c == 9));
      check("t1_done", done, (c == 10));
      tick();
    end
    start = 1'b0;
    @(negedge clk);
    check("b2b_busy", busy, 1);
    check("b2b_cs", m_chipselect, 1);
    check("b2b_addr", m_address, 14'h40);
    tick();
    wait_done(40, 0);

    // Address wrap past the top of memory.
    do_start(14'h3FFE, 15'd4);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("t2_cs", m_chipselect, (c <= 4));
      if (c <= 4) check("t2_addr", m_address, wrap_addr[c-1]);
      if (c >= 2) check("t2_data", st_data, 64'(wrap_addr[c-2]));
      tick();
    end
    wait_done(40, 0);

    // Backpressure for 10 cycles; a start while busy must be ignored.
    st_ready = 1'b0;
    do_start(14'h100, 15'd8);
    cs = 0;
    for (int c = 1; c <= 10; c++) begin
      st_ready = 1'b0;
      if (c == 5) begin
        start = 1'b1; base_address = 14'h999; word_count = 15'd3;
      end else start = 1'b0;
      @(negedge clk);
      if (m_chipselect) cs++;
      tick();
    end
    start = 1'b0;
    check("t3_issues", cs, 4);
    wait_done(40, 0);

    // Zero-length command, then a single-word packet.
    do_start(14'h20, 15'd0);
    @(negedge clk);
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    check("t4_cs", m_chipselect, 0);
    check("t4_valid", st_valid, 0);
    tick();
    do_start(14'h55, 15'd1);
    tick();
    @(negedge clk);
    check("t5_data", st_data, 64'h55);
    check("t5_sop", st_startofpacket, 1);
    check("t5_eop", st_endofpacket, 1);
    tick();
    wait_done(10, 0);

    // Reset in cycle 4 of a running command, then a clean restart.
    do_start(14'h200, 15'd8);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_valid", st_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    tick();
    do_start(14'h300, 15'd3);
    tick();
    @(negedge clk);
    check("t6_sop", st_startofpacket, 1);
    check("t6_data", st_data, 64'h300);
    tick();
    wait_done(20, 0);

    // Full-memory packet under random backpressure.
    d0 = done_pulses;
    e0 = eop_hs;
    do_start(14'h0, 15'd16384);
    wait_done(45000, 1);
    check("t7_done_once", done_pulses - d0, 1);
    check("t7_eop_once", eop_hs - e0, 1);

    tick();
    check("model_drained", exp_q.size(), 0);
    check("issues_drained", addr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
